prefix_adder_scheduler: RTL and testbench

Pipelined, shared carry-lookahead adder service for the execute cluster. It arbitrates round-robin between NREQ requesters (ALU, address generation, multiply accumulate) for a single prefix-tree adder. The adder is split into a group-prefix stage and a carry-resolve/sum stage. A requester can lock the adder to chain multi-word add/sub through a stored carry.

---
 rtl/prefix_adder_scheduler_pkg.sv | 37 +++
 rtl/adder_rr_arbiter.sv | 90 +++++++++
 rtl/prefix_adder_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_prefix_adder_scheduler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefix_adder_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// prefix_adder_scheduler_pkg
//   Shared types for the pipelined prefix-adder service:
//     INPUTSIZE / GROUPSIZE  default operand width and carry group size
//     arb_state_t            lock FSM states of the round-robin arbiter
//     gp_t                   generate/propagate pair
//     gp_combine()           group generate/propagate prefix cell, used for
//                            both halves of the group prefix tree
// ---------------------------------------------------------------------------
`ifndef INPUTSIZE
`define INPUTSIZE 32
`endif
`ifndef GROUPSIZE
`define GROUPSIZE 4
`endif

package prefix_adder_scheduler_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   // Prefix cell: (hi) o (lo). hi is the more significant span.
   function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
      gp_t r;
      r.g = hi.g | (hi.p & lo.g);
      r.p = hi.p & lo.p;
      return r;
   endfunction

endpackage

// File: rtl/adder_rr_arbiter.sv
// ---------------------------------------------------------------------------
// adder_rr_arbiter
//   Round-robin arbiter with lock for the shared adder.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     req_valid    per-requester request
//     req_lock     per-requester "keep the grant after this op"
//     accept_ok    pipeline can take an op this cycle (already reset-gated)
//     grant        one-hot or zero ready vector back to requesters
//     grant_id     index of the granted requester (valid when accept=1)
//     accept       an op is accepted this cycle
// ---------------------------------------------------------------------------
module adder_rr_arbiter
   import prefix_adder_scheduler_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req_valid,
   input  logic [NREQ-1:0] req_lock,
   input  logic            accept_ok,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_id,
   output logic            accept
);

   arb_state_t     state_reg, state_next;
   logic [IDW-1:0] rr_ptr_reg, rr_ptr_next;
   logic [IDW-1:0] owner_reg, owner_next;
   logic           found;
   int             idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         rr_ptr_reg <= '0;
         owner_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         rr_ptr_reg <= rr_ptr_next;
         owner_reg  <= owner_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      rr_ptr_next = rr_ptr_reg;
      owner_next  = owner_reg;
      grant       = '0;
      grant_id    = '0;
      found       = 1'b0;
      idx         = 0;

      case (state_reg)
         IDLE: begin
            // Search starts at rr_ptr and wraps; first valid requester wins.
            for (int i = 0; i < NREQ; i++) begin
               idx = int'(rr_ptr_reg) + i;
               if (idx >= NREQ) idx = idx - NREQ;
               if (!found && req_valid[idx]) begin
                  found    = 1'b1;
                  grant_id = IDW'(idx);
               end
            end
         end
         LOCKED: begin
            grant_id = owner_reg;
            found    = req_valid[owner_reg];
         end
         default: ;
      endcase

      accept = found & accept_ok;

      if (accept) begin
         grant[grant_id] = 1'b1;
         // Both "IDLE accept" and "owner releases" advance past the winner.
         rr_ptr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
         if (req_lock[grant_id]) begin
            state_next = LOCKED;
            owner_next = grant_id;
         end else begin
            state_next = IDLE;
         end
      end
   end

endmodule

// File: rtl/prefix_adder_scheduler.sv
// ---------------------------------------------------------------------------
// prefix_adder_scheduler
//   Shared two-stage prefix-tree adder, arbitrated round-robin between NREQ
//   requesters, with lockable carry chaining for multi-word add/sub.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     req_valid/req_ready        per-requester handshake (ready one-hot/zero)
//     req_a, req_b               operands, requester k at [k*WIDTH +: WIDTH]
//     req_sub                    a + ~b (+1 unless chained)
//     req_chain                  carry-in from the stored chain carry
//     req_lock                   keep the grant after this op
//     rsp_valid/rsp_ready        result handshake
//     rsp_id, rsp_sum,
//     rsp_cout, rsp_ovf          originating requester, sum, carry, overflow
//   S1 holds operands plus the carry-in-free group prefix; the S1->S2
//   transfer applies the carry-in, ripples inside groups and registers the
//   result, which drives rsp_* directly.
// ---------------------------------------------------------------------------
module prefix_adder_scheduler
   import prefix_adder_scheduler_pkg::*;
#(
   parameter int WIDTH = `INPUTSIZE,
   parameter int GROUP = `GROUPSIZE,
   parameter int NREQ  = 2,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ-1:0]       req_sub,
   input  logic [NREQ-1:0]       req_chain,
   input  logic [NREQ-1:0]       req_lock,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_sum,
   output logic                  rsp_cout,
   output logic                  rsp_ovf
);

   localparam int NGRP = WIDTH / GROUP;
   localparam int HALF = NGRP / 2;

   // Ripple a whole group into one generate/propagate pair.
   function automatic gp_t group_gp(input logic [GROUP-1:0] g, input logic [GROUP-1:0] p);
      gp_t acc;
      acc.g = g[0];
      acc.p = p[0];
      for (int j = 1; j < GROUP; j++) begin
         acc = gp_combine('{g: g[j], p: p[j]}, acc);
      end
      return acc;
   endfunction

   // ---------------- flow control and arbitration ----------------
   logic             s1_valid_reg, s2_valid_reg;
   logic             s2_load, s1_adv, accept_ok, accept;
   logic [IDW-1:0]   grant_id;

   assign s2_load   = !s2_valid_reg || rsp_ready;
   assign s1_adv    = s1_valid_reg && s2_load;
   assign accept_ok = (!s1_valid_reg || s1_adv) && rst_n;

   adder_rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_lock  (req_lock),
      .accept_ok (accept_ok),
      .grant     (req_ready),
      .grant_id  (grant_id),
      .accept    (accept)
   );

   // ---------------- operand prep and group prefix (S1 input) ----------------
   logic [WIDTH-1:0] a_sel, b_eff;
   logic             sub_sel, chain_sel;
   logic [WIDTH-1:0] bit_g, bit_p;
   gp_t              grp_gp   [NGRP];
   gp_t              half_pre [NGRP];
   gp_t              pre_tmp;
   logic [NGRP-1:0]  pre_g, pre_p;

   assign a_sel     = req_a[grant_id*WIDTH +: WIDTH];
   assign sub_sel   = req_sub[grant_id];
   assign chain_sel = req_chain[grant_id];
   assign b_eff     = sub_sel ? ~req_b[grant_id*WIDTH +: WIDTH] : req_b[grant_id*WIDTH +: WIDTH];
   assign bit_g     = a_sel & b_eff;
   assign bit_p     = a_sel ^ b_eff;

   genvar gi;
   generate
      for (gi = 0; gi < NGRP; gi++) begin : g_group
         assign grp_gp[gi] = group_gp(bit_g[gi*GROUP +: GROUP], bit_p[gi*GROUP +: GROUP]);
      end
   endgenerate

   // Each half is scanned independently, then the upper half is combined
   // with the lower half's total to give prefixes G[0..i], P[0..i].
   always_comb begin
      half_pre[0] = grp_gp[0];
      for (int i = 1; i < NGRP; i++) begin
         if (i == HALF) half_pre[i] = grp_gp[i];
         else           half_pre[i] = gp_combine(grp_gp[i], half_pre[i-1]);
      end
      pre_g   = '0;
      pre_p   = '0;
      pre_tmp = '0;
      for (int i = 0; i < NGRP; i++) begin
         if (i < HALF) pre_tmp = half_pre[i];
         else          pre_tmp = gp_combine(half_pre[i], half_pre[HALF-1]);
         pre_g[i] = pre_tmp.g;
         pre_p[i] = pre_tmp.p;
      end
   end

   // ---------------- S1 register ----------------
   logic [IDW-1:0]   s1_id_reg;
   logic [WIDTH-1:0] s1_a_reg, s1_b_reg;
   logic             s1_sub_reg, s1_chain_reg;
   logic [NGRP-1:0]  s1_pg_reg, s1_pp_reg;
   logic             chain_c_reg;

   // ---------------- carry resolve and sum (S2 input) ----------------
   logic [WIDTH-1:0] s1_g, s1_p, s2_sum;
   logic             s2_cin, s2_cout, s2_ovf;
   logic [NGRP:0]    grp_cin;
   logic [WIDTH:0]   carry;

   assign s1_g   = s1_a_reg & s1_b_reg;
   assign s1_p   = s1_a_reg ^ s1_b_reg;
   // chain_c is read here, at transfer time, so it always holds the carry
   // of the op that transferred just before this one.
   assign s2_cin = s1_chain_reg ? chain_c_reg : s1_sub_reg;

   always_comb begin
      grp_cin    = '0;
      grp_cin[0] = s2_cin;
      for (int i = 0; i < NGRP; i++) begin
         grp_cin[i+1] = s1_pg_reg[i] | (s1_pp_reg[i] & s2_cin);
      end
      carry = '0;
      for (int g = 0; g < NGRP; g++) begin
         carry[g*GROUP] = grp_cin[g];
         for (int j = 1; j < GROUP; j++) begin
            carry[g*GROUP+j] = s1_g[g*GROUP+j-1] | (s1_p[g*GROUP+j-1] & carry[g*GROUP+j-1]);
         end
      end
      carry[WIDTH] = grp_cin[NGRP];
   end

   assign s2_sum  = s1_p ^ carry[WIDTH-1:0];
   assign s2_cout = carry[WIDTH];
   assign s2_ovf  = carry[WIDTH] ^ carry[WIDTH-1];

   // ---------------- pipeline registers ----------------
   logic [IDW-1:0]   s2_id_reg;
   logic [WIDTH-1:0] s2_sum_reg;
   logic             s2_cout_reg, s2_ovf_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_id_reg    <= '0;
         s1_a_reg     <= '0;
         s1_b_reg     <= '0;
         s1_sub_reg   <= 1'b0;
         s1_chain_reg <= 1'b0;
         s1_pg_reg    <= '0;
         s1_pp_reg    <= '0;
         chain_c_reg  <= 1'b0;
         s2_valid_reg <= 1'b0;
         s2_id_reg    <= '0;
         s2_sum_reg   <= '0;
         s2_cout_reg  <= 1'b0;
         s2_ovf_reg   <= 1'b0;
      end else begin
         if (s1_adv) begin
            chain_c_reg <= s2_cout;
         end
         if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
               s2_id_reg   <= s1_id_reg;
               s2_sum_reg  <= s2_sum;
               s2_cout_reg <= s2_cout;
               s2_ovf_reg  <= s2_ovf;
            end
         end
         if (accept) begin
            s1_valid_reg <= 1'b1;
            s1_id_reg    <= grant_id;
            s1_a_reg     <= a_sel;
            s1_b_reg     <= b_eff;
            s1_sub_reg   <= sub_sel;
            s1_chain_reg <= chain_sel;
            s1_pg_reg    <= pre_g;
            s1_pp_reg    <= pre_p;
         end else if (s1_adv) begin
            s1_valid_reg <= 1'b0;
         end
      end
   end

   assign rsp_valid = s2_valid_reg;
   assign rsp_id    = s2_id_reg;
   assign rsp_sum   = s2_sum_reg;
   assign rsp_cout  = s2_cout_reg;
   assign rsp_ovf   = s2_ovf_reg;

endmodule

// File: tb/tb_prefix_adder_scheduler.sv
// ---------------------------------------------------------------------------
// tb_prefix_adder_scheduler
//   Scoreboard bench: per-requester op queues feed a driver, a negedge
//   monitor turns every accept into an expected result (from an arithmetic
//   model with its own chain carry) and compares it with each consumed
//   response, in order.
// ---------------------------------------------------------------------------
module tb_prefix_adder_scheduler;

   localparam int W = 32;
   localparam int N = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid, req_ready, req_sub, req_chain, req_lock;
   logic [N*W-1:0] req_a, req_b;
   logic           rsp_valid, rsp_ready;
   logic [0:0]     rsp_id;
   logic [W-1:0]   rsp_sum;
   logic           rsp_cout, rsp_ovf;

   always #5 clk = ~clk;

   prefix_adder_scheduler #(.WIDTH(W), .GROUP(4), .NREQ(N), .IDW(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sub   (req_sub),
      .req_chain (req_chain),
      .req_lock  (req_lock),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .rsp_ovf   (rsp_ovf)
   );

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic        chain;
      logic        lock;
   } op_t;

   typedef struct packed {
      int          id;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      int          cyc;
   } exp_t;

   op_t      opq [N][$];
   exp_t     sb [$];
   int       acc_log [$];
   logic [N-1:0] acc_pend = '0;
   int       tests = 0, fails = 0, cyc = 0, last_stall = -10, acc_total = 0;
   logic     chain_m = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input int id, input op_t op, input logic chain_c, input int c);
      exp_t        e;
      logic [31:0] be;
      logic [32:0] s;
      logic        cin;
      be    = op.sub ? ~op.b : op.b;
      cin   = op.chain ? chain_c : op.sub;
      s     = {1'b0, op.a} + {1'b0, be} + {32'd0, cin};
      e.id  = id;
      e.sum = s[31:0];
      e.cout = s[32];
      e.ovf = (op.a[31] == be[31]) && (s[31] != op.a[31]);
      e.cyc = c;
      return e;
   endfunction

   task automatic push(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic chain, input logic lock);
      op_t op;
      op.a = a; op.b = b; op.sub = sub; op.chain = chain; op.lock = lock;
      opq[k].push_back(op);
   endtask

   // Driver: inputs change 1 time unit after each rising edge.
   initial begin
      req_valid = '0; req_sub = '0; req_chain = '0; req_lock = '0;
      req_a = '0; req_b = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < N; k++) begin
            if (acc_pend[k]) begin
               opq[k].delete(0);
               acc_pend[k] = 1'b0;
            end
            if (opq[k].size() > 0) begin
               req_valid[k]       = 1'b1;
               req_a[k*W +: W]    = opq[k][0].a;
               req_b[k*W +: W]    = opq[k][0].b;
               req_sub[k]         = opq[k][0].sub;
               req_chain[k]       = opq[k][0].chain;
               req_lock[k]        = opq[k][0].lock;
            end else begin
               req_valid[k] = 1'b0;
               req_chain[k] = 1'b0;
               req_lock[k]  = 1'b0;
            end
         end
      end
   end

   // Monitor: samples handshakes on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            cyc++;
            check("ready_onehot", ($countones(req_ready) <= 1), 1);
            if (!rsp_ready) last_stall = cyc;
            for (int k = 0; k < N; k++) begin
               if (req_valid[k] && req_ready[k]) begin
                  e = model(k, opq[k][0], chain_m, cyc);
                  chain_m = e.cout;
                  sb.push_back(e);
                  acc_log.push_back(k);
                  acc_pend[k] = 1'b1;
                  acc_total++;
               end
            end
            if (rsp_valid && rsp_ready) begin
               if (sb.size() == 0) begin
                  check("spurious_rsp", rsp_valid, 0);
               end else begin
                  e = sb.pop_front();
                  $display("[TB] rsp id=%0d sum=0x%08h cout=%0d ovf=%0d (exp id=%0d sum=0x%08h cout=%0d ovf=%0d)",
                           rsp_id, rsp_sum, rsp_cout, rsp_ovf, e.id, e.sum, e.cout, e.ovf);
                  check("rsp_id", rsp_id, e.id);
                  check("rsp_sum", rsp_sum, e.sum);
                  check("rsp_cout", rsp_cout, e.cout);
                  check("rsp_ovf", rsp_ovf, e.ovf);
                  // Without any stall since accept: visible two samples later.
                  if (e.cyc > last_stall) check("latency", cyc - e.cyc, 2);
               end
            end
         end
      end
   end

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #2;
         n++;
      end while (n < budget && (opq[0].size() + opq[1].size() + sb.size() != 0 || acc_pend != '0));
      check("drain_timeout", opq[0].size() + opq[1].size() + sb.size(), 0);
   endtask

   initial begin
      logic [31:0] snap_sum;
      logic [0:0]  snap_id;
      int          a0;

      rsp_ready = 1'b1;
      // Reset values (req_valid forced high to show req_ready is held low).
      #2;
      req_valid = '1;
      #1;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_sum", rsp_sum, 0);
      check("rst_rsp_cout", rsp_cout, 0);
      check("rst_rsp_ovf", rsp_ovf, 0);
      check("rst_req_ready", req_ready, 0);
      req_valid = '0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #2;

      // Single op
      push(0, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
      wait_idle(50);

      // Subtract with overflow, then wrap-around add
      push(1, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
      push(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      wait_idle(50);

      // Round robin with both requesters busy
      acc_log.delete();
      for (int i = 0; i < 4; i++) begin
         push(0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
         push(1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      wait_idle(100);
      check("rr_count", acc_log.size(), 8);
      for (int i = 1; i < acc_log.size(); i++) check("rr_alternate", acc_log[i] != acc_log[i-1], 1);

      // Align the pointer to requester 0, then a locked 64-bit chained add
      push(1, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0);
      wait_idle(50);
      acc_log.delete();
      push(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
      push(0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
      push(1, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 1'b0);
      push(1, 32'h0000_0030, 32'h0000_0040, 1'b1, 1'b0, 1'b0);
      wait_idle(100);
      check("lock_count", acc_log.size(), 4);
      if (acc_log.size() == 4) begin
         check("lock_grant0", acc_log[0], 0);
         check("lock_grant1", acc_log[1], 0);
         check("lock_grant2", acc_log[2], 1);
         check("lock_grant3", acc_log[3], 1);
      end

      // Backpressure: two accepts fill both stages, then ready drops
      rsp_ready = 1'b0;
      a0 = acc_total;
      for (int i = 0; i < 3; i++) begin
         push(0, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
         push(1, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
      end
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check("bp_ready_low", req_ready, 0);
      snap_sum = rsp_sum;
      snap_id  = rsp_id;
      @(negedge clk);
      @(negedge clk); #1;
      check("bp_accepts", acc_total - a0, 2);
      check("bp_ready_still_low", req_ready, 0);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_sum_stable", rsp_sum, snap_sum);
      check("bp_id_stable", rsp_id, snap_id);
      @(posedge clk); #2;
      rsp_ready = 1'b1;
      wait_idle(100);

      // Reset with both stages full; in-flight ops must vanish
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) push(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      check("pre_reset_full", rsp_valid, 1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      opq[0].delete();
      opq[1].delete();
      sb.delete();
      acc_pend = '0;
      chain_m  = 1'b0;
      #1;
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_req_ready", req_ready, 0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         check("post_reset_quiet", rsp_valid, 0);
      end
      @(posedge clk); #2;
      push(0, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
      wait_idle(50);

      check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout tests=%0d", tests);
      $fatal(1, "watchdog");
   end

endmodule
